// File: rtl/xif_copro_pkg.sv
// Shared types and instruction patterns for the XIF bit/rotate coprocessor.
// Used by the decoder, the controller and anything talking to the datapath.
package xif_copro_pkg;

    typedef enum logic [1:0] {
        OP_BITREV = 2'd0,
        OP_ROTR   = 2'd1,
        OP_ROTL   = 2'd2,
        OP_NONE   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_COMMIT,
        S_EXEC,
        S_RESP
    } state_e;

    // funct7, funct3 and opcode are significant; rs1/rs2/rd are don't-care
    localparam logic [31:0] INSTR_MASK   = 32'hFE00_707F;
    localparam logic [31:0] PAT_BITREV   = 32'h0400_702B;
    localparam logic [31:0] PAT_ROTRIGHT = 32'h0600_702B;
    localparam logic [31:0] PAT_ROTLEFT  = 32'h0800_702B;

endpackage

// File: rtl/xif_copro_decoder.sv
// Combinational decoder: maps an offloaded instruction word to a datapath op.
// Anything that does not match one of the three patterns is OP_NONE.
module xif_copro_decoder
    import xif_copro_pkg::*;
(
    input  logic [31:0] instr_i,
    output op_e         op_o,
    output logic        supported_o
);

    logic [31:0] masked;

    assign masked = instr_i & INSTR_MASK;

    // pattern match on the significant fields
    always_comb begin
        op_o = OP_NONE;
        unique case (1'b1)
            (masked == PAT_BITREV):   op_o = OP_BITREV;
            (masked == PAT_ROTRIGHT): op_o = OP_ROTR;
            (masked == PAT_ROTLEFT):  op_o = OP_ROTL;
            default:                  op_o = OP_NONE;
        endcase
    end

    assign supported_o = (op_o != OP_NONE);

endmodule

// File: rtl/xif_copro_ctrl.sv
// XIF coprocessor controller: one instruction in flight through
// issue, commit, datapath execution with timeout, and result handshake.
module xif_copro_ctrl
    import xif_copro_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DP_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]         issue_rs1_i,
    input  logic [31:0]         issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,

    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,

    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [31:0]         result_data_o,
    output logic                result_we_o,
    output logic                result_err_o,

    output logic                dp_req_o,
    output op_e                 dp_op_o,
    output logic [31:0]         dp_a_o,
    output logic [4:0]          dp_shamt_o,
    input  logic                dp_done_i,
    input  logic [31:0]         dp_result_i
);

    localparam int CW = $clog2(DP_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DP_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                rdy_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]          rd_q, rd_d;
    op_e                 op_q, op_d;
    logic [31:0]         rs1_q, rs1_d;
    logic [4:0]          shamt_q, shamt_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;

    op_e                 dec_op;
    logic                dec_sup;
    logic                issue_hs;
    logic                unused_rs2;

    // only the low five bits of rs2 matter as a rotate amount
    assign unused_rs2 = ^issue_rs2_i[31:5];

    xif_copro_decoder u_dec (
        .instr_i     (issue_instr_i),
        .op_o        (dec_op),
        .supported_o (dec_sup)
    );

    // rdy_q keeps the port closed until the first edge after reset release
    assign issue_ready_o  = rdy_q & (state_q == S_IDLE);
    assign issue_hs       = issue_valid_i & issue_ready_o;

    assign dp_req_o       = (state_q == S_EXEC);
    assign dp_op_o        = op_q;
    assign dp_a_o         = rs1_q;
    assign dp_shamt_o     = shamt_q;

    assign result_valid_o = (state_q == S_RESP);
    assign result_id_o    = id_q;
    assign result_rd_o    = rd_q;
    assign result_data_o  = data_q;
    assign result_we_o    = result_valid_o & ~err_q;
    assign result_err_o   = result_valid_o & err_q;

    // next-state, latching and offload response
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        id_d              = id_q;
        rd_d              = rd_q;
        op_d              = op_q;
        rs1_d             = rs1_q;
        shamt_d           = shamt_q;
        data_d            = data_q;
        err_d             = err_q;
        issue_accept_o    = 1'b0;
        issue_writeback_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (issue_hs && dec_sup) begin
                    issue_accept_o    = 1'b1;
                    issue_writeback_o = 1'b1;
                    id_d    = issue_id_i;
                    rd_d    = issue_instr_i[11:7];
                    op_d    = dec_op;
                    rs1_d   = issue_rs1_i;
                    shamt_d = (dec_op == OP_BITREV) ? 5'd0
                                                    : issue_rs2_i[4:0];
                    cnt_d   = '0;
                    if (commit_valid_i && commit_id_i == issue_id_i)
                        state_d = commit_kill_i ? S_IDLE : S_EXEC;
                    else
                        state_d = S_WAIT_COMMIT;
                end
            end
            S_WAIT_COMMIT: begin
                if (commit_valid_i && commit_id_i == id_q) begin
                    state_d = commit_kill_i ? S_IDLE : S_EXEC;
                    cnt_d   = '0;
                end
            end
            S_EXEC: begin
                if (dp_done_i) begin
                    data_d  = dp_result_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (result_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, counter and latched instruction fields
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            id_q    <= '0;
            rd_q    <= '0;
            op_q    <= OP_BITREV;
            rs1_q   <= '0;
            shamt_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            shamt_q <= shamt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
